gpio_input_conditioner: RTL and testbench

GPIO_INPUT_CONDITIONER -- requirements
Module: gpio_input_conditioner

---
 rtl/gpio_input_conditioner.sv | 77 +++++++
 tb/tb_gpio_input_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
// Per-channel pad conditioner: 2-flop synchronizer, saturating debounce counter,
// registered edge pulses and sticky, mode-filtered event flags feeding one irq.
module gpio_input_conditioner #(
    parameter int GPIO_WIDTH      = 3,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [GPIO_WIDTH-1:0]   gpio_raw,
    input  logic [2*GPIO_WIDTH-1:0] edge_mode,
    input  logic [GPIO_WIDTH-1:0]   event_clear,
    output logic [GPIO_WIDTH-1:0]   gpio_clean,
    output logic [GPIO_WIDTH-1:0]   gpio_rise,
    output logic [GPIO_WIDTH-1:0]   gpio_fall,
    output logic [GPIO_WIDTH-1:0]   event_pending,
    output logic                    irq
);

    localparam int            CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic [CNT_W-1:0] count;
        logic             clean;
        logic             rise;
        logic             fall;
        logic             pending;
        logic             accept;
        logic             rise_set;
        logic             fall_set;
        logic             event_set;

        // The counter tops out at CNT_LAST, so acceptance happens exactly when the
        // differing level has been seen for DEBOUNCE_CYCLES consecutive edges.
        assign accept    = (sync2 != clean) && (count == CNT_LAST);
        assign rise_set  = accept & sync2;
        assign fall_set  = accept & ~sync2;
        assign event_set = (rise_set & edge_mode[2*i]) | (fall_set & edge_mode[2*i+1]);

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                count   <= '0;
                clean   <= 1'b0;
                rise    <= 1'b0;
                fall    <= 1'b0;
                pending <= 1'b0;
            end else begin
                sync1 <= gpio_raw[i];
                sync2 <= sync1;
                if (sync2 == clean) begin
                    count <= '0;
                end else if (accept) begin
                    clean <= sync2;
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
                rise <= rise_set;
                fall <= fall_set;
                // A new event wins over a clear on the same edge.
                pending <= event_set | (pending & ~event_clear[i]);
            end
        end

        assign gpio_clean[i]    = clean;
        assign gpio_rise[i]     = rise;
        assign gpio_fall[i]     = fall;
        assign event_pending[i] = pending;
    end

    assign irq = |event_pending;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner (3 channels, 4-cycle debounce):
// stimulus queues expected edge pulses, a monitor pops them as they appear.
module tb_gpio_input_conditioner;

    localparam int W = 3;
    localparam int D = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [W-1:0]   gpio_raw;
    logic [2*W-1:0] edge_mode;
    logic [W-1:0]   event_clear;
    logic [W-1:0]   gpio_clean;
    logic [W-1:0]   gpio_rise;
    logic [W-1:0]   gpio_fall;
    logic [W-1:0]   event_pending;
    logic           irq;

    typedef struct {
        int           at;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] clean;
        logic [W-1:0] pend;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    gpio_input_conditioner #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .gpio_raw     (gpio_raw),
        .edge_mode    (edge_mode),
        .event_clear  (event_clear),
        .gpio_clean   (gpio_clean),
        .gpio_rise    (gpio_rise),
        .gpio_fall    (gpio_fall),
        .event_pending(event_pending),
        .irq          (irq)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input logic [W-1:0] r, input logic [W-1:0] f,
                                input logic [W-1:0] c, input logic [W-1:0] p);
        exp_t e;
        e.at = at; e.rise = r; e.fall = f; e.clean = c; e.pend = p;
        sb.push_back(e);
    endtask

    // Monitor: irq consistency every cycle, scoreboard pop on any edge pulse.
    always @(negedge clock) begin
        exp_t e;
        n_tests++;
        if (irq !== |event_pending) begin
            n_fail++;
            $display("FAIL irq_or: irq=%b pending=%b (cycle %0d)", irq, event_pending, cyc);
        end
        if ((gpio_rise | gpio_fall) !== '0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d", gpio_rise, gpio_fall, cyc);
            end else begin
                e = sb.pop_front();
                if (cyc != e.at || gpio_rise !== e.rise || gpio_fall !== e.fall ||
                    gpio_clean !== e.clean || event_pending !== e.pend) begin
                    n_fail++;
                    $display("FAIL pulse: got cyc=%0d rise=%b fall=%b clean=%b pend=%b expected cyc=%0d rise=%b fall=%b clean=%b pend=%b",
                             cyc, gpio_rise, gpio_fall, gpio_clean, event_pending,
                             e.at, e.rise, e.fall, e.clean, e.pend);
                end
            end
        end
    end

    initial begin
        int t;
        reset       = 1'b0;
        gpio_raw    = '0;
        edge_mode   = '0;
        event_clear = '0;
        tick(3);
        chk("reset_outputs", {gpio_clean, gpio_rise, gpio_fall, event_pending, irq}, 0);
        reset = 1'b1;

        // Idle with all pads low.
        for (int k = 0; k < 100; k++) begin
            tick(1);
            chk("idle_zero", {gpio_clean, gpio_rise, gpio_fall, event_pending, irq}, 0);
        end

        // Ch0 rising, mode 01.
        edge_mode = 6'b00_00_01;
        gpio_raw  = 3'b001;
        t = cyc;
        expect_pulse(t + 6, 3'b001, 3'b000, 3'b001, 3'b001);
        tick(5);
        chk("ch0_clean_before", gpio_clean, 3'b000);
        tick(1);
        chk("ch0_clean_at6", gpio_clean, 3'b001);
        chk("ch0_irq", irq, 1);
        tick(2);

        // Ch1 glitch and chatter rejection.
        gpio_raw = 3'b011; tick(3);
        gpio_raw = 3'b001; tick(2);
        for (int k = 0; k < 2; k++) begin
            gpio_raw = 3'b011; tick(2);
            gpio_raw = 3'b001; tick(2);
        end
        tick(8);
        chk("ch1_glitch_clean", gpio_clean, 3'b001);
        chk("ch1_glitch_pend", event_pending, 3'b001);

        // Clear, then clear coinciding with a new accepted event.
        event_clear = 3'b001; tick(1); event_clear = '0;
        chk("clear_pend", event_pending, 3'b000);
        chk("clear_irq", irq, 0);
        gpio_raw = 3'b000;
        t = cyc;
        expect_pulse(t + 6, 3'b000, 3'b001, 3'b000, 3'b000);
        tick(8);
        gpio_raw = 3'b001;
        t = cyc;
        expect_pulse(t + 6, 3'b001, 3'b000, 3'b001, 3'b001);
        tick(5);
        event_clear = 3'b001; tick(1); event_clear = '0;
        tick(2);
        chk("set_beats_clear", event_pending, 3'b001);
        event_clear = 3'b001; tick(1); event_clear = '0;
        chk("late_clear_pend", event_pending, 3'b000);
        chk("late_clear_irq", irq, 0);

        // Ch2 mode 00: pulses only.
        gpio_raw = 3'b101;
        t = cyc;
        expect_pulse(t + 6, 3'b100, 3'b000, 3'b101, 3'b000);
        tick(8);
        gpio_raw = 3'b001;
        t = cyc;
        expect_pulse(t + 6, 3'b000, 3'b100, 3'b001, 3'b000);
        tick(8);

        // Ch2 mode 11: both edges, mode change keeps pending.
        edge_mode = 6'b11_00_01;
        gpio_raw  = 3'b101;
        t = cyc;
        expect_pulse(t + 6, 3'b100, 3'b000, 3'b101, 3'b100);
        tick(8);
        edge_mode = 6'b00_00_01;
        tick(2);
        chk("mode_change_keeps", event_pending, 3'b100);
        edge_mode = 6'b11_00_01;
        gpio_raw  = 3'b001;
        t = cyc;
        expect_pulse(t + 6, 3'b000, 3'b100, 3'b001, 3'b100);
        tick(8);
        chk("ch2_fall_pend", event_pending, 3'b100);

        // Simultaneous events on all channels.
        edge_mode = 6'b11_11_11;
        gpio_raw  = 3'b110;
        t = cyc;
        expect_pulse(t + 6, 3'b110, 3'b001, 3'b110, 3'b111);
        tick(8);
        chk("multi_pend", event_pending, 3'b111);

        // Reset mid-count, pad held high through reset.
        gpio_raw = 3'b001;
        tick(4);
        #2 reset = 1'b0;
        #1 chk("async_reset", {gpio_clean, gpio_rise, gpio_fall, event_pending, irq}, 0);
        tick(2);
        reset = 1'b1;
        t = cyc;
        expect_pulse(t + 6, 3'b001, 3'b000, 3'b001, 3'b001);
        tick(5);
        chk("post_reset_before", gpio_clean, 3'b000);
        tick(4);
        chk("post_reset_clean", gpio_clean, 3'b001);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
